rou_pwr_ctl: RTL and testbench
==============================

ROU_PWR_CTL -- requirements
Module: rou_pwr_ctl

Interface
REQ-001 Parameters SHALL be: DWID, 128, data width; AWID, 32, address width; CWID, 8, command width; WID, 2+DWID+AWID+CWID, roubus word width; OUTW, 4, outstanding-counter width; SETTLE, 8, isolation settle cycles; TMO, 1024, drain timeout cycles.
REQ-002 Clock and reset SHALL be: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-003 Ports SHALL be: rou_in input WID, word from local master; ack_in output 3, ack to master; rou_out output WID, word toward link; ack_out input 3, ack from link; otherside_powered input 1, far side powered; pwr_req input 1, request power-down (level); pwr_ack output 1, link safely off; isolate output 1, clamp enable; state_o output 3, FSM state; err_o output 2, sticky errors.
REQ-004 Roubus word bit WID-1 SHALL be valid, bit WID-2 last; ack bit 0 = accept, bit 1 = complete (one transaction retired), bit 2 = retry.

Function
REQ-005 States SHALL be ON=0, DRAIN=1, ISOLATE=2, OFF=3, WAKE=4, encoded on state_o.
REQ-006 ON: rou_out SHALL equal rou_in and ack_in equal ack_out combinationally (zero latency).
REQ-007 Outstanding counter SHALL +1 on rou_out valid & ack_out[0], -1 on ack_out[1]; both in one cycle -> unchanged; decrement at 0 ignored.
REQ-008 ON with outstanding = 2^OUTW-1: rou_out SHALL be all-zero and ack_in SHALL be {rou_in valid,ack_out[1],0} (retry, completes passed).
REQ-009 ON & pwr_req=1 -> DRAIN next cycle; timeout counter loaded with TMO.
REQ-010 DRAIN: rou_out all-zero; ack_in[2] = rou_in valid, ack_in[1] = ack_out[1], ack_in[0] = 0.
REQ-011 DRAIN & outstanding=0 -> ISOLATE; DRAIN & timeout reaches 0 with outstanding>0 -> ISOLATE, err_o[0] set, outstanding cleared.
REQ-012 otherside_powered=0 in ON or DRAIN -> ISOLATE next cycle; if outstanding>0 err_o[1] set; outstanding cleared.
REQ-013 ISOLATE: isolate=1, rou blocked as DRAIN; after SETTLE cycles -> OFF.
REQ-014 OFF: isolate=1, pwr_ack=1, rou blocked; pwr_req=0 & otherside_powered=1 -> WAKE, settle counter loaded with SETTLE.
REQ-015 WAKE: isolate=0, pwr_ack=1, rou blocked; after SETTLE cycles -> ON with pwr_ack=0; otherside_powered=0 during WAKE -> OFF.
REQ-016 pwr_req reasserted during WAKE SHALL NOT abort WAKE; ON is entered, then DRAIN the following cycle.
REQ-017 pwr_req deasserted during DRAIN or ISOLATE SHALL be ignored; sequence completes to OFF.
REQ-018 err_o bits SHALL be sticky, cleared on entry to WAKE.
REQ-019 isolate, pwr_ack, state_o, err_o SHALL be registered outputs.

Reset
REQ-020 rst_n low SHALL asynchronously force state OFF, isolate=1, pwr_ack=1, err_o=0, outstanding=0, counters=0; rou_out=0, ack_in=0.
REQ-021 After reset release, the block SHALL reach ON only via WAKE (SETTLE cycles minimum).
REQ-022 Reset mid-DRAIN SHALL discard outstanding count without setting err_o.

Structure
REQ-023 Package rou_pkg SHALL hold the state enum, ack bit indices (ACK_ACC, ACK_CMP, ACK_RTY) and valid/last bit offsets as functions of WID.
REQ-024 One sub-module rou_pwr_timer (load value, enable, zero flag, width clog2(TMO+1)) SHALL serve both settle and timeout counting.

Verification
REQ-025 Reset, pwr_req=0, otherside_powered=1 -> WAKE 8 cycles, ON at cycle 9, isolate falls at WAKE entry, pwr_ack falls at ON.
REQ-026 ON, issue 3 accepted words, pwr_req=1, return 3 completes over 5 cycles -> DRAIN until last complete, ISOLATE 8 cycles, OFF, pwr_ack=1, err_o=0; valid input during DRAIN gets ack_in=3'b100.
REQ-027 DRAIN with 2 outstanding, no completes -> ISOLATE after 1024 cycles, err_o=2'b01.
REQ-028 ON with 1 outstanding, otherside_powered drops -> ISOLATE next cycle, err_o=2'b10; return to ON clears err_o at WAKE.
REQ-029 15 accepts without completes -> 16th valid gets retry, rou_out zero; simultaneous accept+complete keeps count 15.
REQ-030 pwr_req pulsed in WAKE cycle 3 -> ON for exactly 1 cycle, then DRAIN.

Source files
------------

// File: rtl/rou_pkg.sv
// rtl/rou_pkg.sv - shared types and roubus bit positions for the power controller
package rou_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ISOLATE = 3'd2,
    ST_OFF     = 3'd3,
    ST_WAKE    = 3'd4
  } pwr_state_e;

  localparam int ACK_ACC = 0;
  localparam int ACK_CMP = 1;
  localparam int ACK_RTY = 2;

  function automatic int valid_bit(input int wid);
    return wid - 1;
  endfunction

  function automatic int last_bit(input int wid);
    return wid - 2;
  endfunction

endpackage

// File: rtl/rou_pwr_timer.sv
// rtl/rou_pwr_timer.sv - loadable down-counter shared by the settle and drain-timeout phases
module rou_pwr_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserts in the cycle whose clock edge takes the count to zero, so a load of N spans N cycles.
  assign zero_o = (cnt_q <= ONE);

endmodule

// File: rtl/rou_pwr_ctl.sv
// rtl/rou_pwr_ctl.sv - roubus power-down controller: drain, isolate, off and wake sequencing
module rou_pwr_ctl
  import rou_pkg::*;
#(
  parameter int DWID   = 128,
  parameter int AWID   = 32,
  parameter int CWID   = 8,
  parameter int WID    = 2 + DWID + AWID + CWID,
  parameter int OUTW   = 4,
  parameter int SETTLE = 8,
  parameter int TMO    = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WID-1:0] rou_in,
  output logic [2:0]     ack_in,
  output logic [WID-1:0] rou_out,
  input  logic [2:0]     ack_out,
  input  logic           otherside_powered,
  input  logic           pwr_req,
  output logic           pwr_ack,
  output logic           isolate,
  output logic [2:0]     state_o,
  output logic [1:0]     err_o
);

  localparam int              VB        = valid_bit(WID);
  localparam int              TW        = $clog2(TMO + 1);
  localparam logic [OUTW-1:0] OUT_MAX   = '1;
  localparam logic [TW-1:0]   LD_SETTLE = TW'(SETTLE);
  localparam logic [TW-1:0]   LD_TMO    = TW'(TMO);

  pwr_state_e      state_q, state_d;
  logic [OUTW-1:0] out_q, out_d;
  logic [1:0]      err_q, err_d;
  logic            isolate_q, isolate_d;
  logic            pwr_ack_q, pwr_ack_d;
  logic            pend_q, pend_d;
  logic            tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            blocked, inc, dec, clr_out;

  // Traffic passes only in ON with room left in the outstanding counter.
  assign blocked = (state_q != ST_ON) || (out_q == OUT_MAX);
  assign rou_out = blocked ? '0 : rou_in;

  always_comb begin
    ack_in = '0;
    if (rst_n) begin
      if (blocked) begin
        ack_in[ACK_RTY] = rou_in[VB];
        ack_in[ACK_CMP] = ack_out[ACK_CMP];
      end else begin
        ack_in = ack_out;
      end
    end
  end

  assign inc = rou_out[VB] & ack_out[ACK_ACC];
  assign dec = ack_out[ACK_CMP];

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    pend_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = LD_SETTLE;
    case (state_q)
      ST_ON: begin
        if (!otherside_powered) begin
          state_d = ST_ISOLATE;
          if (out_q != '0) err_d[1] = 1'b1;
        end else if (pwr_req || pend_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!otherside_powered) begin
          state_d = ST_ISOLATE;
          if (out_q != '0) err_d[1] = 1'b1;
        end else if (out_q == '0) begin
          state_d = ST_ISOLATE;
        end else if (tmr_zero) begin
          state_d  = ST_ISOLATE;
          err_d[0] = 1'b1;
        end
      end
      ST_ISOLATE: begin
        if (tmr_zero) state_d = ST_OFF;
      end
      ST_OFF: begin
        if (!pwr_req && otherside_powered) begin
          state_d = ST_WAKE;
          err_d   = '0;
        end
      end
      ST_WAKE: begin
        // A request seen while waking is held so ON is entered before draining.
        pend_d = pend_q | pwr_req;
        if (!otherside_powered) begin
          state_d = ST_OFF;
        end else if (tmr_zero) begin
          state_d = ST_ON;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
    if (state_d != state_q) begin
      case (state_d)
        ST_DRAIN: begin
          tmr_load = 1'b1;
          tmr_val  = LD_TMO;
        end
        ST_ISOLATE, ST_WAKE: begin
          tmr_load = 1'b1;
        end
        default: begin
          tmr_load = 1'b0;
        end
      endcase
    end
  end

  assign tmr_en  = (state_q == ST_DRAIN) || (state_q == ST_ISOLATE) || (state_q == ST_WAKE);
  assign clr_out = (state_d == ST_ISOLATE) && (state_q != ST_ISOLATE);

  always_comb begin
    out_d = out_q;
    if (clr_out) begin
      out_d = '0;
    end else if (inc && !dec) begin
      out_d = out_q + 1'b1;
    end else if (dec && !inc && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end
  end

  assign isolate_d = (state_d == ST_ISOLATE) || (state_d == ST_OFF);
  assign pwr_ack_d = (state_d == ST_OFF) || (state_d == ST_WAKE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      out_q     <= '0;
      err_q     <= '0;
      isolate_q <= 1'b1;
      pwr_ack_q <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      err_q     <= err_d;
      isolate_q <= isolate_d;
      pwr_ack_q <= pwr_ack_d;
      pend_q    <= pend_d;
    end
  end

  rou_pwr_timer #(
    .W (TW)
  ) u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  assign state_o = state_q;
  assign err_o   = err_q;
  assign isolate = isolate_q;
  assign pwr_ack = pwr_ack_q;

endmodule

// File: tb/tb_rou_pwr_ctl.sv
// tb/tb_rou_pwr_ctl.sv - self-checking bench for rou_pwr_ctl with a cycle-level reference model
module tb_rou_pwr_ctl;

  localparam int WID     = 2 + 128 + 32 + 8;
  localparam int SETTLE  = 8;
  localparam int TMO     = 1024;
  localparam int OUT_MAX = 15;
  localparam int S_ON = 0, S_DRAIN = 1, S_ISO = 2, S_OFF = 3, S_WAKE = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [WID-1:0] rou_in;
  logic [2:0]     ack_in;
  logic [WID-1:0] rou_out;
  logic [2:0]     ack_out;
  logic           otherside_powered;
  logic           pwr_req;
  logic           pwr_ack;
  logic           isolate;
  logic [2:0]     state_o;
  logic [1:0]     err_o;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_st, m_out, m_age;
  logic [1:0] m_err;
  bit         m_pend;

  typedef struct {
    logic       v;
    logic [2:0] ao;
    logic [2:0] exp_ack;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  rou_pwr_ctl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rou_in            (rou_in),
    .ack_in            (ack_in),
    .rou_out           (rou_out),
    .ack_out           (ack_out),
    .otherside_powered (otherside_powered),
    .pwr_req           (pwr_req),
    .pwr_ack           (pwr_ack),
    .isolate           (isolate),
    .state_o           (state_o),
    .err_o             (err_o)
  );

  task automatic chk_n(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [WID-1:0] act, input logic [WID-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WID-1:0] mk_word(input logic v);
    logic [191:0]   r;
    logic [WID-1:0] w;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w = r[WID-1:0];
    w[WID-1] = v;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [2:0] ao);
    rou_in  = mk_word(v);
    ack_out = ao;
  endtask

  task automatic model_reset();
    m_st   = S_OFF;
    m_out  = 0;
    m_age  = 0;
    m_err  = 2'b00;
    m_pend = 1'b0;
  endtask

  // Advances the model over one clock edge using the inputs currently applied.
  task automatic model_step();
    int   nxt, inc, dec;
    logic blk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    blk = (m_st != S_ON) || (m_out == OUT_MAX);
    inc = (!blk && rou_in[WID-1] && ack_out[0]) ? 1 : 0;
    dec = ack_out[1] ? 1 : 0;
    nxt = m_st;
    case (m_st)
      S_ON, S_DRAIN: begin
        if (!otherside_powered) begin
          nxt = S_ISO;
          if (m_out > 0) m_err[1] = 1'b1;
        end else if (m_st == S_ON) begin
          if (pwr_req || m_pend) nxt = S_DRAIN;
        end else if (m_out == 0) begin
          nxt = S_ISO;
        end else if (m_age + 1 >= TMO) begin
          nxt = S_ISO;
          m_err[0] = 1'b1;
        end
      end
      S_ISO: if (m_age + 1 >= SETTLE) nxt = S_OFF;
      S_OFF: begin
        if (!pwr_req && otherside_powered) begin
          nxt   = S_WAKE;
          m_err = 2'b00;
        end
      end
      default: begin
        if (!otherside_powered) nxt = S_OFF;
        else if (m_age + 1 >= SETTLE) nxt = S_ON;
      end
    endcase
    m_pend = (m_st == S_WAKE) && (m_pend || pwr_req);
    if (nxt == S_ISO && m_st != S_ISO) begin
      m_out = 0;
    end else begin
      m_out = m_out + inc - dec;
      if (m_out < 0) m_out = 0;
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  task automatic check_model(input string nm);
    logic           blk;
    logic [2:0]     ea;
    logic [WID-1:0] er;
    blk = (m_st != S_ON) || (m_out == OUT_MAX);
    er  = blk ? '0 : rou_in;
    if (!rst_n) ea = 3'b000;
    else if (blk) ea = {rou_in[WID-1], ack_out[1], 1'b0};
    else ea = ack_out;
    chk_n({nm, " state"}, int'(state_o), m_st);
    chk_n({nm, " isolate"}, int'(isolate), (m_st == S_ISO || m_st == S_OFF) ? 1 : 0);
    chk_n({nm, " pwr_ack"}, int'(pwr_ack), (m_st == S_OFF || m_st == S_WAKE) ? 1 : 0);
    chk_n({nm, " err"}, int'(err_o), int'(m_err));
    chk_n({nm, " ack_in"}, int'(ack_in), int'(ea));
    chk_w({nm, " rou_out"}, rou_out, er);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick(input string nm);
    #1;
    check_model(nm);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input int tgt, input int budget, output int n);
    n = 0;
    while (int'(state_o) != tgt && n < budget) begin
      tick("wait");
      n++;
    end
    if (int'(state_o) != tgt) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_state: state %0d expected %0d within %0d cycles", state_o, tgt, budget);
    end
  endtask

  initial begin
    int n;
    logic [2:0] ao;

    tbl[0] = '{1'b0, 3'b000, 3'b000};
    tbl[1] = '{1'b1, 3'b001, 3'b001};
    tbl[2] = '{1'b1, 3'b100, 3'b100};
    tbl[3] = '{1'b0, 3'b010, 3'b010};
    tbl[4] = '{1'b0, 3'b010, 3'b010};
    tbl[5] = '{1'b1, 3'b011, 3'b011};
    tbl[6] = '{1'b1, 3'b001, 3'b001};
    tbl[7] = '{1'b1, 3'b111, 3'b111};

    rst_n = 1'b0;
    pwr_req = 1'b0;
    otherside_powered = 1'b1;
    drive(1'b1, 3'b111);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_n("rst state", int'(state_o), S_OFF);
    chk_n("rst isolate", int'(isolate), 1);
    chk_n("rst pwr_ack", int'(pwr_ack), 1);
    chk_n("rst err", int'(err_o), 0);
    chk_n("rst ack_in", int'(ack_in), 0);
    chk_w("rst rou_out", rou_out, '0);
    tick("reset");

    // Power-up: one OFF cycle, eight WAKE cycles, then ON.
    rst_n = 1'b1;
    drive(1'b0, 3'b000);
    tick("wake0");
    chk_n("wake entry state", int'(state_o), S_WAKE);
    chk_n("wake entry isolate", int'(isolate), 0);
    chk_n("wake entry pwr_ack", int'(pwr_ack), 1);
    wait_state(S_ON, 20, n);
    chk_n("wake length", n, SETTLE);
    chk_n("on pwr_ack", int'(pwr_ack), 0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].ao);
      #1;
      chk_n($sformatf("vec%0d ack_in", i), int'(ack_in), int'(tbl[i].exp_ack));
      chk_w($sformatf("vec%0d rou_out", i), rou_out, rou_in);
      tick("vec");
    end
    drive(1'b0, 3'b010);
    tick("vec_tail");

    // Drain with three outstanding, completions spread over five cycles.
    repeat (3) begin
      drive(1'b1, 3'b001);
      tick("issue");
    end
    pwr_req = 1'b1;
    drive(1'b0, 3'b000);
    tick("req");
    chk_n("drain entry", int'(state_o), S_DRAIN);
    for (int i = 0; i < 5; i++) begin
      ao = (i % 2 == 0) ? 3'b010 : 3'b000;
      drive(1'b1, ao);
      #1;
      chk_n("drain ack_in", int'(ack_in), (i % 2 == 0) ? 6 : 4);
      tick("drain");
      if (i < 4) chk_n("drain hold", int'(state_o), S_DRAIN);
    end
    drive(1'b0, 3'b000);
    chk_n("drain last cycle", int'(state_o), S_DRAIN);
    tick("drain_end");
    chk_n("isolate entry", int'(state_o), S_ISO);
    repeat (3) tick("iso");
    pwr_req = 1'b0;
    wait_state(S_OFF, 20, n);
    chk_n("isolate rest", n, SETTLE - 3);
    chk_n("off pwr_ack", int'(pwr_ack), 1);
    chk_n("off isolate", int'(isolate), 1);
    chk_n("off err", int'(err_o), 0);

    // Request pulsed on the third WAKE cycle: ON for one cycle, then DRAIN.
    tick("off");
    tick("w1");
    tick("w2");
    pwr_req = 1'b1;
    tick("w3");
    pwr_req = 1'b0;
    wait_state(S_ON, 20, n);
    chk_n("wake rest", n, SETTLE - 3);
    tick("on1");
    chk_n("on one cycle", int'(state_o), S_DRAIN);
    wait_state(S_WAKE, 40, n);
    wait_state(S_ON, 20, n);

    // Far side drops with one outstanding.
    drive(1'b1, 3'b001);
    tick("one");
    otherside_powered = 1'b0;
    drive(1'b0, 3'b000);
    tick("drop");
    chk_n("drop state", int'(state_o), S_ISO);
    chk_n("drop err", int'(err_o), 2);
    wait_state(S_OFF, 20, n);
    chk_n("drop isolate len", n, SETTLE);
    tick("off_hold");
    chk_n("off hold", int'(state_o), S_OFF);
    otherside_powered = 1'b1;
    tick("off_wake");
    chk_n("err clear", int'(err_o), 0);
    wait_state(S_ON, 20, n);

    // Saturation of the outstanding counter.
    repeat (14) begin
      drive(1'b1, 3'b001);
      tick("fill");
    end
    drive(1'b1, 3'b011);
    #1;
    chk_w("acc+cmp pass", rou_out, rou_in);
    tick("accmp");
    drive(1'b1, 3'b001);
    #1;
    chk_w("15th pass", rou_out, rou_in);
    tick("fifteen");
    drive(1'b1, 3'b001);
    #1;
    chk_n("sat ack_in", int'(ack_in), 4);
    chk_w("sat rou_out", rou_out, '0);
    tick("sat");
    drive(1'b1, 3'b011);
    #1;
    chk_n("sat cmp ack_in", int'(ack_in), 6);
    tick("sat_cmp");
    drive(1'b1, 3'b000);
    #1;
    chk_w("unsat pass", rou_out, rou_in);
    tick("unsat");
    repeat (12) begin
      drive(1'b0, 3'b010);
      tick("ret");
    end

    // Drain timeout with two outstanding.
    pwr_req = 1'b1;
    drive(1'b0, 3'b000);
    tick("req2");
    chk_n("tmo drain", int'(state_o), S_DRAIN);
    wait_state(S_ISO, TMO + 50, n);
    chk_n("tmo length", n, TMO);
    chk_n("tmo err", int'(err_o), 1);
    wait_state(S_OFF, 20, n);
    pwr_req = 1'b0;
    wait_state(S_ON, 30, n);

    // Reset in the middle of a drain discards the outstanding count.
    repeat (2) begin
      drive(1'b1, 3'b001);
      tick("pre");
    end
    pwr_req = 1'b1;
    drive(1'b0, 3'b000);
    tick("req3");
    tick("drain3");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_n("mid rst state", int'(state_o), S_OFF);
    chk_n("mid rst err", int'(err_o), 0);
    tick("mid_rst");
    pwr_req = 1'b0;
    rst_n = 1'b1;
    wait_state(S_ON, 30, n);
    pwr_req = 1'b1;
    tick("req4");
    chk_n("post rst drain", int'(state_o), S_DRAIN);
    pwr_req = 1'b0;
    tick("drain4");
    chk_n("post rst empty", int'(state_o), S_ISO);
    wait_state(S_ON, 40, n);

    for (int i = 0; i < 3000; i++) begin
      ao[0] = 1'($urandom_range(0, 1));
      ao[2] = ($urandom_range(0, 7) == 0);
      ao[1] = ((i / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), ao);
      pwr_req = ($urandom_range(0, 15) == 0);
      otherside_powered = ($urandom_range(0, 99) != 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
